// File: rtl/exe_stage.sv
// Execute stage of the pipeline.
// Operand forwarding, operand-2 generation (rotated immediate, memory offset
// or shifted register), a 9-operation ALU with {N,Z,C,V} flags, branch target
// computation, and the registered status flags.
// Everything except the status register is combinational. Reset clears only
// the status register.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcIn,
    input  logic [3:0]  aluCmdIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic        branchIn,
    input  logic        sIn,
    input  logic [31:0] regRnIn,
    input  logic [31:0] regRmIn,
    input  logic        immIn,
    input  logic [11:0] shiftOperandIn,
    input  logic [23:0] imm24In,
    input  logic [1:0]  selSrc1,
    input  logic [1:0]  selSrc2,
    input  logic [31:0] memAluRes,
    input  logic [31:0] wbValue,
    input  logic        freeze,
    output logic [31:0] aluRes,
    output logic [31:0] storeVal,
    output logic [31:0] branchAddr,
    output logic        branchTaken,
    output logic [3:0]  status
);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;

    logic [31:0] opA;
    logic [31:0] val2;
    logic [31:0] shifted;
    logic [63:0] immRot;
    logic [63:0] rorWide;
    logic [4:0]  rotAmt;
    logic [4:0]  shAmt;
    logic [31:0] asrVal;
    logic [32:0] sum33;
    logic [31:0] res;
    logic        cIn;
    logic        nNew;
    logic        zNew;
    logic        cNew;
    logic        vNew;

    // Carry used by ADC/SBC always comes from the registered flags.
    assign cIn = status[1];

    // Forwarding muxes for the first operand and the store data / Rm value.
    always_comb begin
        case (selSrc1)
            2'b01:   opA = memAluRes;
            2'b10:   opA = wbValue;
            default: opA = regRnIn;
        endcase
        case (selSrc2)
            2'b01:   storeVal = memAluRes;
            2'b10:   storeVal = wbValue;
            default: storeVal = regRmIn;
        endcase
    end

    // Rotations are done by shifting a doubled copy so the wrapped bits fall back in.
    assign rotAmt  = {shiftOperandIn[11:8], 1'b0};
    assign immRot  = {24'b0, shiftOperandIn[7:0], 24'b0, shiftOperandIn[7:0]} >> rotAmt;
    assign shAmt   = shiftOperandIn[11:7];
    assign rorWide = {storeVal, storeVal} >> shAmt;
    assign asrVal  = $signed(storeVal) >>> shAmt;

    // Register shifter; a zero amount passes the value through for every type.
    always_comb begin
        shifted = storeVal;
        if (shAmt != 5'd0) begin
            case (shiftOperandIn[6:5])
                2'b00:   shifted = storeVal << shAmt;
                2'b01:   shifted = storeVal >> shAmt;
                2'b10:   shifted = asrVal;
                default: shifted = rorWide[31:0];
            endcase
        end
    end

    // Operand-2 selection: rotated immediate, 12-bit memory offset, or shifted register.
    always_comb begin
        if (immIn)
            val2 = immRot[31:0];
        else if (memReadIn || memWriteIn)
            val2 = {20'b0, shiftOperandIn};
        else
            val2 = shifted;
    end

    // ALU; logic and undefined ops keep the registered C and V.
    always_comb begin
        sum33 = 33'd0;
        res   = 32'd0;
        cNew  = status[1];
        vNew  = status[0];
        case (aluCmdIn)
            OP_MOV: res = val2;
            OP_MVN: res = ~val2;
            OP_ADD, OP_ADC: begin
                sum33 = {1'b0, opA} + {1'b0, val2} +
                        {32'b0, (aluCmdIn == OP_ADC) ? cIn : 1'b0};
                res   = sum33[31:0];
                cNew  = sum33[32];
                vNew  = (opA[31] == val2[31]) && (sum33[31] != opA[31]);
            end
            OP_SUB, OP_SBC: begin
                sum33 = {1'b0, opA} - {1'b0, val2} -
                        {32'b0, (aluCmdIn == OP_SBC) ? ~cIn : 1'b0};
                res   = sum33[31:0];
                cNew  = ~sum33[32];
                vNew  = (opA[31] != val2[31]) && (sum33[31] != opA[31]);
            end
            OP_AND: res = opA & val2;
            OP_ORR: res = opA | val2;
            OP_EOR: res = opA ^ val2;
            default: res = 32'd0;
        endcase
    end

    assign nNew   = res[31];
    assign zNew   = (res == 32'd0);
    assign aluRes = res;

    // Branch target: word offset sign-extended and scaled to bytes.
    assign branchAddr  = pcIn + {{6{imm24In[23]}}, imm24In, 2'b00};
    assign branchTaken = branchIn;

    // Status flags load only for flag-setting instructions that are not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            status <= 4'b0000;
        else if (sIn && !freeze)
            status <= {nNew, zNew, cNew, vNew};
    end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pcIn;
    logic [3:0]  aluCmdIn;
    logic        memReadIn;
    logic        memWriteIn;
    logic        branchIn;
    logic        sIn;
    logic [31:0] regRnIn;
    logic [31:0] regRmIn;
    logic        immIn;
    logic [11:0] shiftOperandIn;
    logic [23:0] imm24In;
    logic [1:0]  selSrc1;
    logic [1:0]  selSrc2;
    logic [31:0] memAluRes;
    logic [31:0] wbValue;
    logic        freeze;
    logic [31:0] aluRes;
    logic [31:0] storeVal;
    logic [31:0] branchAddr;
    logic        branchTaken;
    logic [3:0]  status;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    exe_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pcIn           (pcIn),
        .aluCmdIn       (aluCmdIn),
        .memReadIn      (memReadIn),
        .memWriteIn     (memWriteIn),
        .branchIn       (branchIn),
        .sIn            (sIn),
        .regRnIn        (regRnIn),
        .regRmIn        (regRmIn),
        .immIn          (immIn),
        .shiftOperandIn (shiftOperandIn),
        .imm24In        (imm24In),
        .selSrc1        (selSrc1),
        .selSrc2        (selSrc2),
        .memAluRes      (memAluRes),
        .wbValue        (wbValue),
        .freeze         (freeze),
        .aluRes         (aluRes),
        .storeVal       (storeVal),
        .branchAddr     (branchAddr),
        .branchTaken    (branchTaken),
        .status         (status)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run-time bound
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h required %08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare the status flags with the oldest queued expectation
    task automatic check_status(input string tag);
        if (exp_q.size() == 0) begin
            check_val({tag, "_noexp"}, 32'hDEAD_BEEF, 32'h0);
        end else begin
            check_val(tag, {28'b0, status}, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic imm, input logic [11:0] so, input logic s);
        aluCmdIn       = cmd;
        regRnIn        = rn;
        regRmIn        = rm;
        immIn          = imm;
        shiftOperandIn = so;
        sIn            = s;
        memReadIn      = 1'b0;
        memWriteIn     = 1'b0;
        branchIn       = 1'b0;
        freeze         = 1'b0;
        selSrc1        = 2'b00;
        selSrc2        = 2'b00;
        memAluRes      = 32'h0;
        wbValue        = 32'h0;
        pcIn           = 32'h0;
        imm24In        = 24'h0;
    endtask

    initial begin
        // Reset held; combinational path must still work
        rst = 1'b0;
        drive(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1);
        pcIn    = 32'h0000_0100;
        imm24In = 24'hFFFF_FE;
        #3;
        check_val("reset_status", {28'b0, status}, 32'h0);
        check_val("reset_alu", aluRes, 32'h8000_0000);
        check_val("reset_branch", branchAddr, 32'h0000_00F8);
        step();
        step();
        check_val("reset_hold", {28'b0, status}, 32'h0);

        // Release reset; first qualifying edge loads ADD-overflow flags
        rst = 1'b1;
        step();
        exp_q.push_back(32'h9);
        check_status("add_ovf_status");

        // SBC with C=0: 5-1-1
        drive(4'b0101, 32'd5, 32'h0, 1'b1, 12'h001, 1'b0);
        #1 check_val("sbc_c0", aluRes, 32'd3);
        step();
        exp_q.push_back(32'h9);
        check_status("sbc_hold");

        // SUB 5-5 sets Z and C
        drive(4'b0100, 32'd5, 32'h0, 1'b1, 12'h005, 1'b1);
        #1 check_val("sub_eq", aluRes, 32'd0);
        step();
        exp_q.push_back(32'h6);
        check_status("sub_status");

        // ADC 1+1 with stored carry
        drive(4'b0011, 32'd1, 32'h0, 1'b1, 12'h001, 1'b0);
        #1 check_val("adc_carry", aluRes, 32'd3);
        step();

        // SBC with C=1: 5-1-0
        drive(4'b0101, 32'd5, 32'h0, 1'b1, 12'h001, 1'b0);
        #1 check_val("sbc_c1", aluRes, 32'd4);

        // AND keeps C,V
        drive(4'b0110, 32'h8000_0000, 32'h0, 1'b1, 12'h4FF, 1'b1);
        #1 check_val("and_res", aluRes, 32'h8000_0000);
        step();
        exp_q.push_back(32'hA);
        check_status("and_status");

        // ADD carry out to zero
        drive(4'b0010, 32'hFFFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1);
        #1 check_val("add_carry", aluRes, 32'h0);
        step();
        exp_q.push_back(32'h6);
        check_status("add_carry_status");

        // Freeze suppresses the update, then the re-presented op updates
        drive(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1);
        freeze = 1'b1;
        step();
        exp_q.push_back(32'h6);
        check_status("freeze_hold");
        freeze = 1'b0;
        step();
        exp_q.push_back(32'h9);
        check_status("unfreeze_status");

        // MOV 0 keeps V=1 from the previous flags
        drive(4'b0001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b1);
        step();
        exp_q.push_back(32'h5);
        check_status("mov_keep_v");

        // SUB overflow: 0x80000000 - 1
        drive(4'b0100, 32'h8000_0000, 32'h0, 1'b1, 12'h001, 1'b1);
        #1 check_val("sub_ovf", aluRes, 32'h7FFF_FFFF);
        step();
        exp_q.push_back(32'h3);
        check_status("sub_ovf_status");

        // Shifter and immediates through MOV/MVN
        drive(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b0);
        #1 check_val("asr4", aluRes, 32'hF800_0000);
        drive(4'b0001, 32'h0, 32'h0000_000F, 1'b0, 12'h200, 1'b0);
        #1 check_val("lsl4", aluRes, 32'h0000_00F0);
        drive(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'hFA0, 1'b0);
        #1 check_val("lsr31", aluRes, 32'h0000_0001);
        drive(4'b0001, 32'h0, 32'h0000_0001, 1'b0, 12'h0E0, 1'b0);
        #1 check_val("ror1", aluRes, 32'h8000_0000);
        drive(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h020, 1'b0);
        #1 check_val("lsr0", aluRes, 32'h8000_0000);
        drive(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0);
        #1 check_val("rot_imm", aluRes, 32'hFF00_0000);
        drive(4'b1001, 32'h0, 32'h0, 1'b1, 12'h0FF, 1'b0);
        #1 check_val("mvn", aluRes, 32'hFFFF_FF00);
        drive(4'b0111, 32'h0F0F_0F0F, 32'h0, 1'b1, 12'h0FF, 1'b0);
        #1 check_val("orr", aluRes, 32'h0F0F_0FFF);
        drive(4'b1000, 32'h0F0F_0F0F, 32'h0, 1'b1, 12'h0FF, 1'b0);
        #1 check_val("eor", aluRes, 32'h0F0F_0FF0);
        drive(4'b1111, 32'h1234_5678, 32'h0, 1'b1, 12'h0FF, 1'b0);
        #1 check_val("undef_op", aluRes, 32'h0);

        // Forwarding with memory-offset operand
        drive(4'b0010, 32'h5555_5555, 32'h1111_1111, 1'b0, 12'h004, 1'b0);
        selSrc1    = 2'b01;
        memAluRes  = 32'h10;
        selSrc2    = 2'b10;
        wbValue    = 32'h99;
        memWriteIn = 1'b1;
        #1 check_val("fwd_alu", aluRes, 32'h14);
        check_val("fwd_store", storeVal, 32'h99);

        // Branch target
        drive(4'b0000, 32'h0, 32'h0, 1'b0, 12'h000, 1'b0);
        pcIn     = 32'h0000_0100;
        imm24In  = 24'hFFFF_FE;
        branchIn = 1'b1;
        #1 check_val("branch_addr", branchAddr, 32'h0000_00F8);
        check_val("branch_taken", {31'b0, branchTaken}, 32'h1);

        // Mid-operation asynchronous reset
        drive(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1);
        step();
        exp_q.push_back(32'h9);
        check_status("pre_reset_status");
        rst = 1'b0;
        #2;
        check_val("async_clear", {28'b0, status}, 32'h0);
        step();
        check_val("reset_hold2", {28'b0, status}, 32'h0);
        rst = 1'b1;
        step();
        exp_q.push_back(32'h9);
        check_status("post_reset_status");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
